// File: rtl/multdiv_unit.sv
// multdiv_unit: multicycle signed 32-bit multiply / divide.
// Multiply is radix-2 shift-add on operand magnitudes with a final sign fix.
// Divide is restoring division on magnitudes, truncating toward zero.
// Both take exactly 32 iterations. The result and exception flag are
// registered. data_resultRDY pulses for the single cycle spent in DONE.
module multdiv_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_count;

  // Multiply: running 64-bit product.
  // Divide: {remainder, dividend/quotient shift register}.
  logic [63:0] r_acc;
  // Multiplicand magnitude, shifted left once per iteration.
  logic [63:0] r_mcand;
  // Multiply: multiplier magnitude, shifted right once per iteration.
  // Divide: divisor magnitude, held constant.
  logic [31:0] r_opb;
  logic        r_is_div;
  logic        r_sign_a;
  logic        r_sign_b;
  logic        r_b_zero;
  logic [31:0] r_result;
  logic        r_exception;

  logic        w_start;
  logic        w_start_div;
  logic        w_last;
  logic        w_neg;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [63:0] w_mul_acc;
  logic [32:0] w_div_shift;
  logic        w_div_fits;
  logic [31:0] w_div_diff;
  logic [63:0] w_div_acc;
  logic [63:0] w_acc_next;
  logic [63:0] w_prod;
  logic        w_mul_ovf;
  logic [31:0] w_quo;
  logic [31:0] w_quo_signed;
  logic        w_div_ovf;
  logic [31:0] w_fin_result;
  logic        w_fin_exc;

  // Multiply takes priority when both controls are high.
  assign w_start     = ctrl_MULT | ctrl_DIV;
  assign w_start_div = ctrl_DIV & ~ctrl_MULT;
  assign w_last      = (r_state == S_BUSY) && (r_count == 5'd31);
  assign w_neg       = r_sign_a ^ r_sign_b;

  // Magnitudes. 0x80000000 maps onto itself, which is its correct unsigned value.
  assign w_mag_a = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
  assign w_mag_b = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

  // One shift-add multiply step.
  assign w_mul_acc = r_acc + (r_opb[0] ? r_mcand : 64'd0);

  // One restoring-divide step. The remainder is always below the divisor,
  // so after a successful subtract it fits in 32 bits.
  assign w_div_shift = {r_acc[63:32], r_acc[31]};
  assign w_div_fits  = (w_div_shift >= {1'b0, r_opb});
  assign w_div_diff  = w_div_shift[31:0] - r_opb;
  assign w_div_acc   = w_div_fits ? {w_div_diff, r_acc[30:0], 1'b1}
                                  : {w_div_shift[31:0], r_acc[30:0], 1'b0};

  assign w_acc_next = r_is_div ? w_div_acc : w_mul_acc;

  // Sign fix and overflow detection, applied to the final iteration's output.
  assign w_prod       = w_neg ? (64'd0 - w_mul_acc) : w_mul_acc;
  assign w_mul_ovf    = (w_prod[63:32] != {32{w_prod[31]}});
  assign w_quo        = w_div_acc[31:0];
  assign w_quo_signed = w_neg ? (32'd0 - w_quo) : w_quo;
  // A non-negative quotient of 2^31 is unrepresentable (only -2^31 / -1 gets here).
  assign w_div_ovf    = ~w_neg & w_quo[31];

  // Select the value that will be latched on the edge entering DONE.
  always_comb begin
    w_fin_result = w_prod[31:0];
    w_fin_exc    = w_mul_ovf;
    if (r_is_div) begin
      if (r_b_zero) begin
        w_fin_result = 32'd0;
        w_fin_exc    = 1'b1;
      end else begin
        w_fin_result = w_quo_signed;
        w_fin_exc    = w_div_ovf;
      end
    end
  end

  // Next-state logic: a start edge always restarts, from any state.
  always_comb begin
    w_state_next = r_state;
    if (w_start) begin
      w_state_next = S_BUSY;
    end else begin
      case (r_state)
        S_IDLE:  w_state_next = S_IDLE;
        S_BUSY:  w_state_next = (r_count == 5'd31) ? S_DONE : S_BUSY;
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Iteration counter: cleared on start, advanced once per BUSY cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_count <= 5'd0;
    end else if (w_start) begin
      r_count <= 5'd0;
    end else if (r_state == S_BUSY) begin
      r_count <= r_count + 5'd1;
    end
  end

  // Datapath: capture operands on start, then one iteration per BUSY cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_acc    <= 64'd0;
      r_mcand  <= 64'd0;
      r_opb    <= 32'd0;
      r_is_div <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_b_zero <= 1'b0;
    end else if (w_start) begin
      r_acc    <= w_start_div ? {32'd0, w_mag_a} : 64'd0;
      r_mcand  <= {32'd0, w_mag_a};
      r_opb    <= w_mag_b;
      r_is_div <= w_start_div;
      r_sign_a <= data_operandA[31];
      r_sign_b <= data_operandB[31];
      r_b_zero <= (data_operandB == 32'd0);
    end else if (r_state == S_BUSY) begin
      r_acc   <= w_acc_next;
      r_mcand <= r_mcand << 1;
      if (!r_is_div) begin
        r_opb <= r_opb >> 1;
      end
    end
  end

  // Output registers: load only on the edge that completes iteration 31.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_result    <= 32'd0;
      r_exception <= 1'b0;
    end else if (w_last && !w_start) begin
      r_result    <= w_fin_result;
      r_exception <= w_fin_exc;
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exception;
  assign data_resultRDY = (r_state == S_DONE);

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: stimulus pushes expected results with
// their due edge, a negedge monitor checks RDY timing, result and exception.
module tb_multdiv_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  multdiv_unit dut (
    .clk            (clk),
    .clr            (clr),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          ecount   = 0;
  int          errors   = 0;
  int          checks   = 0;
  logic [31:0] hold_res = 32'd0;
  logic        hold_exc = 1'b0;

  always @(posedge clk) ecount <= ecount + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (edge %0d)", name, got, want, ecount);
    end
  endtask

  // Reference model from signed arithmetic on 64-bit integers.
  function automatic void ref_model(input bit is_div, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] r, output logic e);
    longint p;
    if (!is_div) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(r)));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      r = 32'h80000000;
      e = 1'b1;
    end else begin
      r = $signed(a) / $signed(b);
      e = 1'b0;
    end
  endfunction

  // Monitor: every cycle, RDY must match the scoreboard, outputs must hold.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic exp_rdy;
    exp_rdy = (sb.size() > 0) && (sb[0].due == ecount);
    chk("rdy", {31'd0, data_resultRDY}, {31'd0, exp_rdy});
    if (exp_rdy) begin
      e = sb.pop_front();
      hold_res = e.res;
      hold_exc = e.exc;
      $display("done edge=%0d result=%h exc=%0d (want %h/%0d)",
               ecount, data_result, data_exception, e.res, e.exc);
    end
    chk("result", data_result, hold_res);
    chk("exception", {31'd0, data_exception}, {31'd0, hold_exc});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Issue a start pulse; called 2 time units after a rising edge.
  task automatic start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (sb.size() > 0 && sb[sb.size()-1].due >= ecount + 1) begin
      void'(sb.pop_back());
    end
    ref_model(d && !m, a, b, e.res, e.exc);
    e.due = ecount + 1 + 32;
    sb.push_back(e);
    $display("start edge=%0d %s a=%h b=%h expect=%h exc=%0d",
             ecount + 1, (d && !m) ? "DIV " : "MULT", a, b, e.res, e.exc);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    tick(1);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  logic [31:0] specials [0:7];

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          mode;
    int          op;
    int          gap;

    specials[0] = 32'h00000000; specials[1] = 32'h00000001;
    specials[2] = 32'hFFFFFFFF; specials[3] = 32'h80000000;
    specials[4] = 32'h7FFFFFFF; specials[5] = 32'h00010000;
    specials[6] = 32'hFFFF0000; specials[7] = 32'h0000B505;

    clr = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = 32'd0; data_operandB = 32'd0;
    tick(2);
    chk("reset_result", data_result, 32'd0);
    chk("reset_exc", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    clr = 1'b0;
    tick(2);

    // Directed cases, each allowed to complete.
    start(1, 0, 32'd7, 32'hFFFFFFFA);        tick(34);
    start(1, 0, 32'h00010000, 32'h00010000); tick(34);
    start(1, 0, 32'h80000000, 32'd1);        tick(34);
    start(0, 1, 32'hFFFFFF9C, 32'd7);        tick(34);
    start(0, 1, 32'h80000000, 32'hFFFFFFFF); tick(34);
    start(0, 1, 32'd5, 32'd0);               tick(34);
    // Abort a multiply with a divide ten edges later.
    start(1, 0, 32'd3, 32'd4);               tick(9);
    start(0, 1, 32'd20, 32'd4);              tick(34);
    // Both controls high: multiply wins.
    start(1, 1, 32'd6, 32'd3);               tick(34);
    // Back-to-back: second start on the edge after the first RDY cycle begins.
    start(1, 0, 32'd11, 32'hFFFFFFF3);       tick(32);
    start(0, 1, 32'd1000, 32'hFFFFFFFD);     tick(34);

    // Reset mid-operation.
    start(1, 0, 32'd9, 32'd9);
    tick(15);
    clr = 1'b1;
    #1;
    chk("clr_result", data_result, 32'd0);
    chk("clr_exc", {31'd0, data_exception}, 32'd0);
    chk("clr_rdy", {31'd0, data_resultRDY}, 32'd0);
    sb.delete();
    hold_res = 32'd0;
    hold_exc = 1'b0;
    tick(1);
    clr = 1'b0;
    tick(40);
    start(1, 0, 32'd9, 32'd9);               tick(34);

    // Randomized operations with random spacing (some abort, some back-to-back).
    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin a = $urandom; b = $urandom; end
        1: begin
             a = $urandom_range(0, 2000) - 1000;
             b = $urandom_range(0, 60) - 30;
           end
        2: begin a = specials[$urandom_range(0, 7)]; b = specials[$urandom_range(0, 7)]; end
        default: begin a = $urandom; b = 32'd0; end
      endcase
      op = $urandom_range(0, 4);
      if (op == 4) start(1, 1, a, b);
      else if (op >= 2) start(0, 1, a, b);
      else start(1, 0, a, b);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 31) : $urandom_range(32, 35);
      tick(gap);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 100 && sb.size() > 0; i++) tick(1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
